// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Pipeline hazard controller for the 5-stage RV64 core (F, D, E, M, W).
// It generates the stall, flush and forwarding controls for every stage.
// It sequences multi-cycle mul/div ops that sit in E.
// It holds the pipeline while a data-memory access in M waits.
// It also resolves load-use, redirect and write-back-to-decode bypass hazards.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   : StallCycles counts the cycles with StallF=1 and saturates at
//               all ones. Only reset clears it.
//   undefined : no counter logic is built and StallCycles is tied to 0.
//
// Parameters
//   DIV_LAT      total cycles a mul/div op occupies E (2..255)
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   Rs1D, Rs2D                       decode-stage source registers
//   Rs1E, Rs2E, RdE                  execute-stage sources / destination
//   RdM, RdW                         memory / write-back destinations
//   RegWriteE/M/W                    destination-write flags per stage
//   ResultSrcE                       2'b01 marks a load in E
//   MultiCycleE                      E holds a mul/div-class op
//   PCSrcE                           taken branch / jump resolved in E
//   MemReqM, MemReadyM               data-memory request / completion in M
//   StallF/D/E/M                     hold the stage's pipeline register
//   FlushD, FlushE                   turn the stage's register into a bubble
//   BubbleM, BubbleW                 bubble into M / suppress the W write enable
//   ForwardAE/BE                     E operand select (00 RF, 10 M, 01 W)
//   ForwardAD/BD                     D operand takes ResultW
//   MulDivDoneE                      last cycle of a mul/div op in E
//   StallCycles                      stall-cycle performance counter
// -----------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        MultiCycleE,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        BubbleM,
  output logic        BubbleW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        MulDivDoneE,
  output logic [31:0] StallCycles
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MULDIV  = 2'd1,
    S_MEMWAIT = 2'd2
  } state_t;

  // The first cycle of the op is spent in RUN.
  // The last cycle is the one with cnt==0.
  // So the counter loads DIV_LAT-2.
  localparam logic [7:0] CNT_LOAD = 8'(DIV_LAT - 2);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_resume;     // 1: return to MULDIV, 0: return to RUN

  state_t     w_state_next;
  logic [7:0] w_cnt_next;
  logic       w_resume_next;

  logic w_miss;
  logic w_load_use;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_bubble_m, w_bubble_w, w_done;

  // ---------------------------------------------------------------------------
  // Forwarding: operand 0 is A (rs1), operand 1 is B (rs2). x0 never matches.
  // ---------------------------------------------------------------------------
  logic [4:0] w_rs_e [2];
  logic [4:0] w_rs_d [2];
  logic [1:0] w_fwd_e [2];
  logic       w_fwd_d [2];

  assign w_rs_e[0] = Rs1E;
  assign w_rs_e[1] = Rs2E;
  assign w_rs_d[0] = Rs1D;
  assign w_rs_d[1] = Rs2D;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic w_hit_m, w_hit_w;
      assign w_hit_m = RegWriteM && (RdM != 5'd0) && (RdM == w_rs_e[gi]);
      assign w_hit_w = RegWriteW && (RdW != 5'd0) && (RdW == w_rs_e[gi]);
      // The M result is younger, so it wins over W.
      assign w_fwd_e[gi] = w_hit_m ? 2'b10 : (w_hit_w ? 2'b01 : 2'b00);
      assign w_fwd_d[gi] = RegWriteW && (RdW != 5'd0) && (RdW == w_rs_d[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_miss     = MemReqM && !MemReadyM;
  assign w_load_use = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // ---------------------------------------------------------------------------
  // Next-state and control decode.
  // A memory miss takes priority in every state.
  // Its outputs apply in the miss cycle itself, so M never advances past an
  // unfinished access, and the mul/div counter freezes in that cycle too.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_resume_next = r_resume;
    w_stall_f     = 1'b0;
    w_stall_d     = 1'b0;
    w_stall_e     = 1'b0;
    w_stall_m     = 1'b0;
    w_flush_d     = 1'b0;
    w_flush_e     = 1'b0;
    w_bubble_m    = 1'b0;
    w_bubble_w    = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_miss) begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_bubble_w} = 5'b11111;
          w_resume_next = 1'b0;
          w_state_next  = S_MEMWAIT;
        end else if (MultiCycleE) begin
          {w_stall_f, w_stall_d, w_stall_e, w_bubble_m} = 4'b1111;
          w_cnt_next   = CNT_LOAD;
          w_state_next = S_MULDIV;
        end else if (PCSrcE) begin
          // A redirect squashes the younger instruction in D.
          // That makes any load-use stall against it pointless.
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_load_use) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end

      S_MULDIV: begin
        // Done may also show while a miss holds E.
        // The op then finishes again after the wait, with cnt still 0.
        w_done = (r_cnt == 8'd0);
        if (w_miss) begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_bubble_w} = 5'b11111;
          w_resume_next = 1'b1;
          w_state_next  = S_MEMWAIT;
        end else if (r_cnt != 8'd0) begin
          {w_stall_f, w_stall_d, w_stall_e, w_bubble_m} = 4'b1111;
          w_cnt_next = r_cnt - 8'd1;
        end else begin
          w_state_next = S_RUN;
        end
      end

      S_MEMWAIT: begin
        {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_bubble_w} = 5'b11111;
        if (MemReadyM) begin
          w_state_next = r_resume ? S_MULDIV : S_RUN;
        end
      end

      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_RUN;
      r_cnt    <= 8'd0;
      r_resume <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_resume <= w_resume_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are gated by reset_n, so every control is 0 while reset is held.
  // This includes the purely combinational forwarding selects.
  // ---------------------------------------------------------------------------
  assign StallF      = reset_n & w_stall_f;
  assign StallD      = reset_n & w_stall_d;
  assign StallE      = reset_n & w_stall_e;
  assign StallM      = reset_n & w_stall_m;
  assign FlushD      = reset_n & w_flush_d;
  assign FlushE      = reset_n & w_flush_e;
  assign BubbleM     = reset_n & w_bubble_m;
  assign BubbleW     = reset_n & w_bubble_w;
  assign MulDivDoneE = reset_n & w_done;
  assign ForwardAE   = reset_n ? w_fwd_e[0] : 2'b00;
  assign ForwardBE   = reset_n ? w_fwd_e[1] : 2'b00;
  assign ForwardAD   = reset_n & w_fwd_d[0];
  assign ForwardBD   = reset_n & w_fwd_d[1];

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= 32'd0;
    end else if (StallF && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
`else
  assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  typedef struct packed {
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        rwe, rwm, rww;
    logic [1:0]  rse;
    logic        mce, pcs, mreq, mrdy;
    logic [14:0] exp;   // {SF,SD,SE,SM,FD,FE,BM,BW,FAE[1:0],FBE[1:0],FAD,FBD,DONE}
  } vec_t;

  logic        clk, reset_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        MultiCycleE, PCSrcE, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleM, BubbleW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD, MulDivDoneE;
  logic [31:0] StallCycles;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_sc = 0;

  hazard_sequencer #(.DIV_LAT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM), .BubbleW(BubbleW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MulDivDoneE(MulDivDoneE), .StallCycles(StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ex(input logic sf, sd, se, sm, fd, fe, bm, bw,
                                     input logic [1:0] fae, fbe,
                                     input logic fad, fbd, dn);
    return {sf, sd, se, sm, fd, fe, bm, bw, fae, fbe, fad, fbd, dn};
  endfunction

  function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                              input logic rwe, rwm, rww, input logic [1:0] rse,
                              input logic mce, pcs, mreq, mrdy, input logic [14:0] e);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.rse = rse;
    v.mce = mce; v.pcs = pcs; v.mreq = mreq; v.mrdy = mrdy; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE = v.rse; MultiCycleE = v.mce; PCSrcE = v.pcs;
    MemReqM = v.mreq; MemReadyM = v.mrdy;
  endtask

  task automatic check_now(input string nm, input logic [14:0] e);
    logic [14:0] got;
    logic [31:0] sc_exp;
    got = {StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleM, BubbleW,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, MulDivDoneE};
`ifdef HAZARD_PERF_CNT_EN
    sc_exp = exp_sc;
`else
    sc_exp = 32'd0;
`endif
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s outputs: got %b want %b (SF SD SE SM FD FE BM BW FAE FBE FAD FBD DONE)",
               nm, got, e);
    end
    n_cmp++;
    if (StallCycles !== sc_exp) begin
      n_bad++;
      $display("FAIL %s StallCycles: got %0d want %0d", nm, StallCycles, sc_exp);
    end
    $display("  %s: outs=%b stall_cycles=%0d", nm, got, StallCycles);
  endtask

  // Drive one cycle of inputs at the falling edge and check just after.
  // The model stall counter then advances for the coming rising edge.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #1;
    check_now(nm, v.exp);
    if (reset_n && v.exp[14]) exp_sc++;
  endtask

  vec_t tbl [16];
  vec_t idle, v;
  logic [14:0] O_NONE, O_MEMW, O_DIV, O_LU, O_RD, O_DONE;

  initial begin
    O_NONE = 15'd0;
    O_MEMW = ex(1,1,1,1,0,0,0,1,2'b00,2'b00,0,0,0);
    O_DIV  = ex(1,1,1,0,0,0,1,0,2'b00,2'b00,0,0,0);
    O_LU   = ex(1,1,0,0,0,1,0,0,2'b00,2'b00,0,0,0);
    O_RD   = ex(0,0,0,0,1,1,0,0,2'b00,2'b00,0,0,0);
    O_DONE = ex(0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1);
    idle   = mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 0,0,0,0, O_NONE);

    //             rs1d rs2d rs1e rs2e rde rdm rdw rwe rwm rww rse   mce pcs req rdy
    tbl[0]  = mk(0,0,0,0,0,0,0,  1,1,1,2'b01, 0,0,0,0, O_NONE);       // x0 never matches
    tbl[1]  = mk(0,0,5,6,0,5,0,  0,1,0,2'b00, 0,0,0,0, ex(0,0,0,0,0,0,0,0,2'b10,2'b00,0,0,0));
    tbl[2]  = mk(0,0,5,0,0,9,5,  0,1,1,2'b00, 0,0,0,0, ex(0,0,0,0,0,0,0,0,2'b01,2'b00,0,0,0));
    tbl[3]  = mk(0,0,3,3,0,3,3,  0,1,1,2'b00, 0,0,0,0, ex(0,0,0,0,0,0,0,0,2'b10,2'b10,0,0,0));
    tbl[4]  = mk(0,0,4,3,0,3,3,  0,0,1,2'b00, 0,0,0,0, ex(0,0,0,0,0,0,0,0,2'b00,2'b01,0,0,0));
    tbl[5]  = mk(7,7,0,0,0,0,7,  0,0,1,2'b00, 0,0,0,0, ex(0,0,0,0,0,0,0,0,2'b00,2'b00,1,1,0));
    tbl[6]  = mk(7,7,0,0,0,0,7,  0,0,0,2'b00, 0,0,0,0, O_NONE);
    tbl[7]  = mk(8,7,0,0,7,0,0,  1,0,0,2'b01, 0,0,0,0, O_LU);
    tbl[8]  = mk(7,0,0,0,7,0,0,  1,0,0,2'b00, 0,0,0,0, O_NONE);       // not a load
    tbl[9]  = mk(7,0,0,0,7,0,0,  0,0,0,2'b01, 0,0,0,0, O_NONE);       // load without write
    tbl[10] = mk(7,0,0,0,7,0,0,  1,0,0,2'b10, 0,0,0,0, O_NONE);
    tbl[11] = mk(0,0,0,0,0,0,0,  0,0,0,2'b00, 0,1,0,0, O_RD);
    tbl[12] = mk(7,0,0,0,7,0,0,  1,0,0,2'b01, 0,1,0,0, O_RD);         // redirect beats load-use
    tbl[13] = mk(8,7,0,0,7,0,0,  1,0,0,2'b01, 0,0,1,1, O_LU);         // ready with request
    tbl[14] = mk(0,0,2,2,0,0,2,  0,0,1,2'b00, 0,0,1,1, ex(0,0,0,0,0,0,0,0,2'b01,2'b01,0,0,0));
    tbl[15] = mk(9,0,0,0,9,0,9,  1,0,1,2'b01, 0,0,0,0, ex(1,1,0,0,0,1,0,0,2'b00,2'b00,1,0,0));

    // Reset: busy inputs, but every output must read 0.
    reset_n = 1'b0;
    drive(idle);
    step(mk(7,7,5,5,7,5,7, 1,1,1,2'b01, 0,1,0,0, O_NONE), "reset_busy");
    #2 reset_n = 1'b1;

    for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // ld x7 ; add x8,x7,x1
    step(mk(7,1,0,0,7,0,0, 1,0,0,2'b01, 0,0,0,0, O_LU),   "ldu_stall");
    step(mk(7,1,0,0,0,7,0, 0,1,0,2'b00, 0,0,0,0, O_NONE), "ldu_bubble");
    step(mk(0,0,7,1,0,0,7, 0,0,1,2'b00, 0,0,0,0,
            ex(0,0,0,0,0,0,0,0,2'b01,2'b00,0,0,0)),      "ldu_fwd_w");

    // Plain div: seven stalled cycles, then done on the eighth.
    for (int c = 1; c <= 8; c++)
      step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,0,0, (c < 8) ? O_DIV : O_DONE),
           $sformatf("div_c%0d", c));
    step(idle, "div_after");

    // Miss in the 3rd div cycle; the wait spans cycles 3..6 with ready in 6.
    for (int c = 1; c <= 12; c++) begin
      if (c >= 3 && c <= 5)
        v = mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,1,0, O_MEMW);
      else if (c == 6)
        v = mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,1,1, O_MEMW);
      else
        v = mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,0,0, (c < 12) ? O_DIV : O_DONE);
      step(v, $sformatf("divmiss_c%0d", c));
    end
    step(idle, "divmiss_after");

    // Miss during the done cycle: done shows again after the wait.
    for (int c = 1; c <= 7; c++)
      step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,0,0, O_DIV), $sformatf("donemiss_c%0d", c));
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,1,0, O_MEMW | O_DONE), "donemiss_c8");
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,1,1, O_MEMW), "donemiss_c9");
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,0,0, O_DONE), "donemiss_c10");
    step(idle, "donemiss_after");

    // Miss together with MultiCycleE in RUN: wait first, then the div starts.
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,1,0, O_MEMW), "mixmiss_c1");
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,1,1, O_MEMW), "mixmiss_c2");
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,0,0, O_DIV),  "mixmiss_c3");
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 1,0,0,0, O_DIV),  "mixmiss_c4");
    // Reset mid-MULDIV: the outputs must drop without waiting for a clock edge.
    #2 reset_n = 1'b0;
    exp_sc = 0;
    #1 check_now("rst_muldiv_async", O_NONE);
    step(idle, "rst_muldiv_held");
    #2 reset_n = 1'b1;
    step(idle, "rst_muldiv_run");

    // Reset mid-MEMWAIT.
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 0,0,1,0, O_MEMW), "rstmw_c1");
    step(mk(0,0,0,0,0,0,0, 0,0,0,2'b00, 0,0,1,0, O_MEMW), "rstmw_c2");
    #2 reset_n = 1'b0;
    exp_sc = 0;
    #1 check_now("rst_memwait_async", O_NONE);
    step(idle, "rst_memwait_held");
    #2 reset_n = 1'b1;
    step(idle, "rst_memwait_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller for the 5-stage RV64 core (F, D, E, M, W). It sits beside the decode/register-file stage and drives stall, flush and forwarding controls for all stages. It sequences multi-cycle mul/div operations in execute and wait states on the data-memory handshake. It also resolves load-use, branch/jump redirect and write-back-to-decode bypass hazards.

## Interface
- DIV_LAT, 8: total cycles a mul/div op occupies E; legal range 2..255.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  decode-stage source registers
- Rs1E, Rs2E, RdE  in  5  execute-stage sources and destination
- RdM, RdW  in  5  memory- and write-back-stage destinations
- RegWriteE, RegWriteM, RegWriteW  in  1  destination-write flags per stage
- ResultSrcE  in  2  2'b01 marks a load in E
- MultiCycleE  in  1  E holds a mul/div-class op
- PCSrcE  in  1  taken branch or jump resolved in E
- MemReqM, MemReadyM  in  1  data-memory request and completion in M
- StallF, StallD, StallE, StallM  out  1  hold the stage's pipeline register
- FlushD, FlushE  out  1  clear the stage's register to a bubble
- BubbleM, BubbleW  out  1  insert a bubble into M / suppress enableW
- ForwardAE, ForwardBE  out  2  E operand select: 00 register file, 10 from M, 01 from W
- ForwardAD, ForwardBD  out  1  D operand takes ResultW (same-cycle write-back bypass)
- MulDivDoneE  out  1  last cycle of a mul/div op in E
- StallCycles  out  32  stall-cycle count (see Configuration)

## Operation
- FSM states: RUN, MULDIV, MEMWAIT. Additional registers: 8-bit cnt, 1-bit resume (return state).
- MEMWAIT entry: from RUN or MULDIV when MemReqM=1 and MemReadyM=0. resume records the source state; cnt freezes.
- MEMWAIT outputs: StallF/D/E/M=1, BubbleW=1. Exit when MemReadyM=1, back to the resume state.
- MULDIV entry: in RUN with MultiCycleE=1 and no memory wait. Outputs StallF/D/E=1, BubbleM=1. Load cnt=DIV_LAT-2; next state MULDIV.
- MULDIV operation: while cnt!=0, hold the same stalls and decrement cnt. When cnt==0, drop the stalls, assert MulDivDoneE=1, next state RUN.
- Redirect (RUN only): PCSrcE=1 gives FlushD=1 and FlushE=1; StallF=StallD=0.
- Load-use (RUN, no redirect): applies when ResultSrcE=01, RegWriteE=1, RdE!=0 and RdE equals Rs1D or Rs2D. Gives StallF=StallD=1 and FlushE=1 for one cycle.
- Priority: MEMWAIT > MULDIV > redirect > load-use.
- ForwardAE/BE (combinational, all states): 10 if RegWriteM, RdM!=0 and RdM==Rs1E/Rs2E. Otherwise 01 if the same conditions hold for W. Otherwise 00. M wins over W.
- ForwardAD/BD: 1 when RegWriteW, RdW!=0 and RdW==Rs1D/Rs2D.
- Register x0 never matches in any comparison.

## Timing
- While reset_n=0: state RUN, cnt=0, resume=RUN, StallCycles=0; every output is forced to 0.
- After reset release, all outputs are combinational from state and inputs, with zero-cycle latency.
- A mul/div op entering E at cycle t leaves E at the end of cycle t+DIV_LAT-1. MulDivDoneE is high in cycle t+DIV_LAT-1 only.
- A miss during the MulDivDoneE cycle returns to MULDIV with cnt=0; done re-asserts after MemReadyM, and the op is not restarted.
- A miss and MultiCycleE in the same RUN cycle: MEMWAIT first, then the mul/div starts on return.
- MemReadyM=1 in the same cycle as MemReqM: no wait state.
- Load-use hazard after a redirect: the redirect flush applies and no load-use stall is issued.
- Asserting reset_n mid-MULDIV or mid-MEMWAIT aborts immediately to RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined: StallCycles increments on every cycle with StallF=1 and saturates at 32'hFFFF_FFFF. It is cleared only by reset.
- HAZARD_PERF_CNT_EN undefined: no counter logic is built; StallCycles is tied to 0 and the port is kept.

## Test plan
- Back-to-back add x5 then sub using x5 -> ForwardAE=10 in the sub's E cycle. The next dependent op sees ForwardAE=01.
- ld x7 followed by add x8,x7,x1 -> exactly one cycle of StallF=StallD=FlushE=1, then ForwardAE=01.
- div with DIV_LAT=8 -> StallE high for 7 cycles and MulDivDoneE on the 8th. BubbleM is high during the 7 stalled cycles.
- Miss in M during the 3rd cycle of a div, MemReadyM after 4 cycles -> cnt is frozen; the total div occupancy of E is 12 cycles.
- Taken beq together with a load-use match -> FlushD=FlushE=1, StallD=0.
- Reset asserted mid-MULDIV -> all outputs 0 asynchronously. With HAZARD_PERF_CNT_EN defined, StallCycles reads 0 afterwards.
